// File: rtl/hcsr04_pkg.sv
// Shared definitions for the HC-SR04 ranging controller: FSM encoding and
// default timing constants for a 50 MHz clock.
package hcsr04_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TRIG,
        S_WAIT_RISE,
        S_MEASURE,
        S_DIVIDE,
        S_HOLDOFF
    } state_t;

    localparam int TRIG_CYCLES_50M    = 500;
    localparam int PERIOD_CYCLES_50M  = 3_000_000;
    localparam int TIMEOUT_CYCLES_50M = 1_500_000;
    localparam int CYC_PER_CM_50M     = 2915;

endpackage

// File: rtl/hcsr04_div.sv
// Sequential restoring divider: one quotient bit per cycle, the first bit is
// produced on the cycle go is sampled, done pulses CNT_W cycles after go.
module hcsr04_div #(
    parameter int CNT_W = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             go,
    input  logic [CNT_W-1:0] dividend,
    input  logic [CNT_W-1:0] divisor,
    output logic             done,
    output logic [CNT_W-1:0] quotient
);

    localparam int STEP_W = $clog2(CNT_W + 1);
    localparam logic [STEP_W-1:0] STEPS_AFTER_GO = STEP_W'(CNT_W - 1);
    localparam logic [STEP_W-1:0] LAST_STEP      = STEP_W'(1);

    logic [CNT_W-1:0]  rem_q, quo_q;
    logic [CNT_W-1:0]  src_rem, src_quo;
    logic [CNT_W-1:0]  rem_d, quo_d, diff;
    logic [CNT_W:0]    trial;
    logic [STEP_W-1:0] steps_q;
    logic              run_q;

    // NOTE: every variable gets a value before any branch, so no latch is inferred.
    always_comb begin
        src_rem = go ? '0 : rem_q;
        src_quo = go ? dividend : quo_q;
        trial   = {src_rem, src_quo[CNT_W-1]};
        diff    = trial[CNT_W-1:0] - divisor;
        rem_d   = trial[CNT_W-1:0];
        quo_d   = {src_quo[CNT_W-2:0], 1'b0};
        if (trial >= {1'b0, divisor}) begin
            rem_d = diff;
            quo_d = {src_quo[CNT_W-2:0], 1'b1};
        end
    end

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q   <= '0;
            quo_q   <= '0;
            steps_q <= '0;
            run_q   <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (go) begin
                rem_q   <= rem_d;
                quo_q   <= quo_d;
                steps_q <= STEPS_AFTER_GO;
                run_q   <= 1'b1;
            end else if (run_q) begin
                rem_q   <= rem_d;
                quo_q   <= quo_d;
                steps_q <= steps_q - LAST_STEP;
                if (steps_q == LAST_STEP) begin
                    run_q <= 1'b0;
                    done  <= 1'b1;
                end
            end
        end
    end

    assign quotient = quo_q;

endmodule

// File: rtl/hcsr04_ranger.sv
// HC-SR04 ranging controller: trigger generation, echo width measurement,
// conversion to centimetres and timeout detection.
module hcsr04_ranger
    import hcsr04_pkg::*;
#(
    parameter int TRIG_CYCLES    = TRIG_CYCLES_50M,
    parameter int PERIOD_CYCLES  = PERIOD_CYCLES_50M,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_50M,
    parameter int CNT_W          = 24,
    parameter int CYC_PER_CM     = CYC_PER_CM_50M,
    parameter int DIST_W         = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              mode,
    input  logic              start,
    input  logic              echo,
    output logic              trigger,
    output logic              busy,
    output logic [CNT_W-1:0]  echo_cycles,
    output logic [DIST_W-1:0] distance_cm,
    output logic              valid,
    output logic              timeout
);

    localparam logic [CNT_W-1:0]  TRIG_N    = CNT_W'(TRIG_CYCLES);
    localparam logic [CNT_W-1:0]  PERIOD_N  = CNT_W'(PERIOD_CYCLES);
    localparam logic [CNT_W-1:0]  TIMEOUT_N = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0]  DIVISOR   = CNT_W'(CYC_PER_CM);
    localparam logic [CNT_W-1:0]  ONE       = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    localparam logic [DIST_W-1:0] DIST_MAX  = '1;

    state_t            state_q, state_d;
    logic              echo_meta, echo_s, echo_d;
    logic              echo_rise, echo_fall;
    logic [CNT_W-1:0]  trig_cnt, period_cnt, echo_cnt, meas_q;
    logic              to_trig, div_go, pub_to, pub_div;
    logic              div_done;
    logic [CNT_W-1:0]  quotient;
    logic [DIST_W-1:0] dist_sat;

    // Two-flop synchroniser plus one history flop for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            echo_meta <= 1'b0;
            echo_s    <= 1'b0;
            echo_d    <= 1'b0;
        end else begin
            echo_meta <= echo;
            echo_s    <= echo_meta;
            echo_d    <= echo_s;
        end
    end

    assign echo_rise = echo_s & ~echo_d;
    assign echo_fall = ~echo_s & echo_d;

    always_comb begin
        state_d = state_q;
        to_trig = 1'b0;
        div_go  = 1'b0;
        pub_to  = 1'b0;
        pub_div = 1'b0;
        if (!enable) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: if (mode || start) begin
                    state_d = S_TRIG;
                    to_trig = 1'b1;
                end
                S_TRIG: if (trig_cnt >= TRIG_N) state_d = S_WAIT_RISE;
                S_WAIT_RISE: begin
                    if (echo_rise) begin
                        state_d = S_MEASURE;
                    end else if (echo_cnt >= TIMEOUT_N) begin
                        state_d = S_HOLDOFF;
                        pub_to  = 1'b1;
                    end
                end
                S_MEASURE: begin
                    if (echo_cnt >= TIMEOUT_N) begin
                        state_d = S_HOLDOFF;
                        pub_to  = 1'b1;
                    end else if (echo_fall) begin
                        state_d = S_DIVIDE;
                        div_go  = 1'b1;
                    end
                end
                S_DIVIDE: if (div_done) begin
                    state_d = S_HOLDOFF;
                    pub_div = 1'b1;
                end
                S_HOLDOFF: if (period_cnt >= PERIOD_N) begin
                    if (mode) begin
                        state_d = S_TRIG;
                        to_trig = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // The rise-detect cycle already belongs to the pulse, so the count restarts at one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trig_cnt   <= '0;
            period_cnt <= '0;
            echo_cnt   <= '0;
        end else begin
            if (to_trig) begin
                trig_cnt <= ONE;
            end else if (state_q == S_TRIG && trig_cnt != CNT_MAX) begin
                trig_cnt <= trig_cnt + ONE;
            end

            if (to_trig) begin
                period_cnt <= ONE;
            end else if (state_q != S_IDLE && period_cnt != CNT_MAX) begin
                period_cnt <= period_cnt + ONE;
            end

            case (state_q)
                S_TRIG: echo_cnt <= '0;
                S_WAIT_RISE: begin
                    if (echo_rise) echo_cnt <= ONE;
                    else if (echo_cnt != CNT_MAX) echo_cnt <= echo_cnt + ONE;
                end
                S_MEASURE: if (echo_s && echo_cnt != CNT_MAX) echo_cnt <= echo_cnt + ONE;
                default: echo_cnt <= echo_cnt;
            endcase
        end
    end

    hcsr04_div #(
        .CNT_W(CNT_W)
    ) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .go       (div_go),
        .dividend (echo_cnt),
        .divisor  (DIVISOR),
        .done     (div_done),
        .quotient (quotient)
    );

    assign dist_sat = (|quotient[CNT_W-1:DIST_W]) ? DIST_MAX : quotient[DIST_W-1:0];

    // Results are staged in meas_q and published only together with valid,
    // so an abort or reset never exposes a partial measurement.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            trigger     <= 1'b0;
            valid       <= 1'b0;
            timeout     <= 1'b0;
            echo_cycles <= '0;
            distance_cm <= '0;
            meas_q      <= '0;
        end else begin
            state_q <= state_d;
            trigger <= (state_d == S_TRIG);
            valid   <= pub_to | pub_div;
            if (div_go) meas_q <= echo_cnt;
            if (pub_to) begin
                timeout     <= 1'b1;
                distance_cm <= DIST_MAX;
                echo_cycles <= (state_q == S_MEASURE) ? TIMEOUT_N : '0;
            end else if (pub_div) begin
                timeout     <= 1'b0;
                distance_cm <= dist_sat;
                echo_cycles <= meas_q;
            end
        end
    end

    assign busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_hcsr04_ranger.sv
// Directed bench for hcsr04_ranger with shortened timing so the whole run stays brief.
module tb_hcsr04_ranger;

    localparam int TRIG_CYCLES    = 50;
    localparam int PERIOD_CYCLES  = 4000;
    localparam int TIMEOUT_CYCLES = 3500;
    localparam int CYC_PER_CM     = 291;
    localparam int CNT_W          = 24;
    localparam int DIST_W         = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic enable = 1'b0;
    logic mode = 1'b0;
    logic start = 1'b0;
    logic echo = 1'b0;
    logic trigger, busy, valid, timeout;
    logic [CNT_W-1:0]  echo_cycles;
    logic [DIST_W-1:0] distance_cm;

    int total = 0;
    int bad = 0;
    int valid_cnt = 0;
    int trig_rises = 0;
    logic trig_prev = 1'b0;

    hcsr04_ranger #(
        .TRIG_CYCLES    (TRIG_CYCLES),
        .PERIOD_CYCLES  (PERIOD_CYCLES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W),
        .CYC_PER_CM     (CYC_PER_CM),
        .DIST_W         (DIST_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .mode        (mode),
        .start       (start),
        .echo        (echo),
        .trigger     (trigger),
        .busy        (busy),
        .echo_cycles (echo_cycles),
        .distance_cm (distance_cm),
        .valid       (valid),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (valid === 1'b1) valid_cnt++;
        if (trigger === 1'b1 && trig_prev !== 1'b1) trig_rises++;
        trig_prev = trigger;
    end

    // which: 0 = trigger, 1 = valid, 2 = busy; n counts negedges waited.
    task automatic wait_sig(input int which, input logic lvl, input int limit,
                            output int n, output bit ok);
        logic s;
        n  = 0;
        ok = 1'b0;
        while (!ok && n < limit) begin
            @(negedge clk);
            n++;
            case (which)
                0:       s = trigger;
                1:       s = valid;
                default: s = busy;
            endcase
            ok = (s === lvl);
        end
    endtask

    task automatic pulse_start_and_check(input string tag);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        total++;
        if (trigger !== 1'b1) begin
            bad++;
            $display("FAIL %s_trig_on_start: trigger=%b want 1", tag, trigger);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b0; mode = 1'b0; start = 1'b0; echo = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (trigger !== 1'b0) begin bad++; $display("FAIL rst_trigger: got %b want 0", trigger); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", valid); end
        total++; if (timeout !== 1'b0) begin bad++; $display("FAIL rst_timeout: got %b want 0", timeout); end
        total++; if (echo_cycles !== '0) begin bad++; $display("FAIL rst_echo_cycles: got %0d want 0", echo_cycles); end
        total++; if (distance_cm !== '0) begin bad++; $display("FAIL rst_distance: got %0d want 0", distance_cm); end
        rst_n = 1'b1;
        enable = 1'b1;
        repeat (20) @(negedge clk);
        total++; if (trig_rises != 0) begin bad++; $display("FAIL idle_no_trigger: rises=%0d want 0", trig_rises); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_single_shot();
        int n;
        bit ok;
        int v0, r0;
        v0 = valid_cnt;
        r0 = trig_rises;
        pulse_start_and_check("single");
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy: got %b want 1", busy); end
        wait_sig(0, 1'b0, TRIG_CYCLES + 10, n, ok);
        total++;
        if (!ok || n != TRIG_CYCLES) begin
            bad++; $display("FAIL single_trig_width: got %0d cycles (ok=%0b) want %0d", n, ok, TRIG_CYCLES);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        echo = 1'b1;
        repeat (2910) @(negedge clk);
        echo = 1'b0;
        wait_sig(1, 1'b1, 60, n, ok);
        total++;
        if (!ok || n > CNT_W + 4) begin
            bad++; $display("FAIL single_latency: got %0d cycles (ok=%0b) want <= %0d", n, ok, CNT_W + 4);
        end
        total++;
        if (echo_cycles < 2909 || echo_cycles > 2911) begin
            bad++; $display("FAIL single_echo_cycles: got %0d want 2910+/-1", echo_cycles);
        end
        total++; if (distance_cm !== 10'd10) begin bad++; $display("FAIL single_distance: got %0d want 10", distance_cm); end
        total++; if (timeout !== 1'b0) begin bad++; $display("FAIL single_timeout: got %b want 0", timeout); end
        wait_sig(2, 1'b0, PERIOD_CYCLES, n, ok);
        total++; if (!ok) begin bad++; $display("FAIL single_back_to_idle: busy still %b after %0d cycles", busy, n); end
        repeat (50) @(negedge clk);
        total++; if (valid_cnt - v0 != 1) begin bad++; $display("FAIL single_valid_count: got %0d want 1", valid_cnt - v0); end
        total++; if (trig_rises - r0 != 1) begin bad++; $display("FAIL single_busy_start_ignored: rises=%0d want 1", trig_rises - r0); end
    endtask

    task automatic test_no_echo();
        int n;
        bit ok;
        int v0;
        v0 = valid_cnt;
        pulse_start_and_check("noecho");
        wait_sig(0, 1'b0, TRIG_CYCLES + 10, n, ok);
        wait_sig(1, 1'b1, TIMEOUT_CYCLES + 20, n, ok);
        total++;
        if (!ok || n < TIMEOUT_CYCLES - 1 || n > TIMEOUT_CYCLES + 3) begin
            bad++; $display("FAIL noecho_valid_time: got %0d cycles (ok=%0b) want about %0d", n, ok, TIMEOUT_CYCLES);
        end
        total++; if (timeout !== 1'b1) begin bad++; $display("FAIL noecho_timeout: got %b want 1", timeout); end
        total++; if (distance_cm !== 10'h3FF) begin bad++; $display("FAIL noecho_distance: got %0d want 1023", distance_cm); end
        total++; if (echo_cycles !== '0) begin bad++; $display("FAIL noecho_echo_cycles: got %0d want 0", echo_cycles); end
        wait_sig(2, 1'b0, PERIOD_CYCLES, n, ok);
        repeat (10) @(negedge clk);
        total++; if (valid_cnt - v0 != 1) begin bad++; $display("FAIL noecho_valid_count: got %0d want 1", valid_cnt - v0); end
    endtask

    task automatic test_stuck_echo();
        int n;
        bit ok;
        int v0;
        v0 = valid_cnt;
        pulse_start_and_check("stuck");
        wait_sig(0, 1'b0, TRIG_CYCLES + 10, n, ok);
        repeat (3) @(negedge clk);
        echo = 1'b1;
        repeat (5000) @(negedge clk);
        total++; if (valid_cnt - v0 != 1) begin bad++; $display("FAIL stuck_valid_count: got %0d want 1", valid_cnt - v0); end
        total++; if (timeout !== 1'b1) begin bad++; $display("FAIL stuck_timeout: got %b want 1", timeout); end
        total++;
        if (echo_cycles !== CNT_W'(TIMEOUT_CYCLES)) begin
            bad++; $display("FAIL stuck_echo_cycles: got %0d want %0d", echo_cycles, TIMEOUT_CYCLES);
        end
        total++; if (distance_cm !== 10'h3FF) begin bad++; $display("FAIL stuck_distance: got %0d want 1023", distance_cm); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL stuck_idle: busy=%b want 0", busy); end
        echo = 1'b0;
        repeat (60) @(negedge clk);
        total++; if (valid_cnt - v0 != 1) begin bad++; $display("FAIL stuck_late_fall: valids=%0d want 1", valid_cnt - v0); end
    endtask

    task automatic test_continuous();
        int n;
        bit ok;
        int v0, r0;
        time t_now, t_prev;
        longint gap;
        v0 = valid_cnt;
        r0 = trig_rises;
        t_prev = 0;
        mode = 1'b1;
        for (int shot = 0; shot < 3; shot++) begin
            wait_sig(0, 1'b1, PERIOD_CYCLES + 10, n, ok);
            total++; if (!ok) begin bad++; $display("FAIL cont_trig_%0d: no trigger within %0d cycles", shot, n); end
            t_now = $time;
            if (shot > 0) begin
                gap = longint'((t_now - t_prev) / 10);
                total++;
                if (gap != PERIOD_CYCLES) begin
                    bad++; $display("FAIL cont_period_%0d: got %0d cycles want %0d", shot, gap, PERIOD_CYCLES);
                end
            end
            t_prev = t_now;
            wait_sig(0, 1'b0, TRIG_CYCLES + 10, n, ok);
            repeat (10) @(negedge clk);
            echo = 1'b1;
            repeat (582) @(negedge clk);
            echo = 1'b0;
            wait_sig(1, 1'b1, 60, n, ok);
            total++; if (!ok) begin bad++; $display("FAIL cont_valid_%0d: none within %0d cycles", shot, n); end
            total++; if (distance_cm !== 10'd2) begin bad++; $display("FAIL cont_distance_%0d: got %0d want 2", shot, distance_cm); end
            total++; if (timeout !== 1'b0) begin bad++; $display("FAIL cont_timeout_%0d: got %b want 0", shot, timeout); end
            if (shot == 2) mode = 1'b0;
        end
        repeat (5) @(negedge clk);
        total++; if (valid_cnt - v0 != 3) begin bad++; $display("FAIL cont_valid_count: got %0d want 3", valid_cnt - v0); end
        wait_sig(2, 1'b0, PERIOD_CYCLES, n, ok);
        total++; if (!ok) begin bad++; $display("FAIL cont_mode_exit: busy still %b", busy); end
        repeat (100) @(negedge clk);
        total++; if (trig_rises - r0 != 3) begin bad++; $display("FAIL cont_rises: got %0d want 3", trig_rises - r0); end
    endtask

    task automatic test_abort();
        int n;
        bit ok;
        int v0, r0;
        v0 = valid_cnt;
        r0 = trig_rises;
        pulse_start_and_check("abort");
        wait_sig(0, 1'b0, TRIG_CYCLES + 10, n, ok);
        repeat (3) @(negedge clk);
        echo = 1'b1;
        repeat (100) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        total++; if (trigger !== 1'b0) begin bad++; $display("FAIL abort_trigger: got %b want 0", trigger); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy: got %b want 0", busy); end
        repeat (50) @(negedge clk);
        echo = 1'b0;
        repeat (60) @(negedge clk);
        total++; if (valid_cnt != v0) begin bad++; $display("FAIL abort_no_valid: got %0d valids want 0", valid_cnt - v0); end
        total++;
        if (echo_cycles < 581 || echo_cycles > 583) begin
            bad++; $display("FAIL abort_echo_held: got %0d want 582+/-1", echo_cycles);
        end
        total++; if (distance_cm !== 10'd2) begin bad++; $display("FAIL abort_distance_held: got %0d want 2", distance_cm); end
        total++; if (timeout !== 1'b0) begin bad++; $display("FAIL abort_timeout_held: got %b want 0", timeout); end
        enable = 1'b1;
        repeat (50) @(negedge clk);
        total++; if (trig_rises - r0 != 1) begin bad++; $display("FAIL abort_start_ignored: rises=%0d want 1", trig_rises - r0); end
    endtask

    task automatic test_reset_mid();
        int r0;
        pulse_start_and_check("rstmid");
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++; if (trigger !== 1'b0) begin bad++; $display("FAIL rstmid_trigger: got %b want 0", trigger); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid: got %b want 0", valid); end
        total++; if (timeout !== 1'b0) begin bad++; $display("FAIL rstmid_timeout: got %b want 0", timeout); end
        total++; if (echo_cycles !== '0) begin bad++; $display("FAIL rstmid_echo_cycles: got %0d want 0", echo_cycles); end
        total++; if (distance_cm !== '0) begin bad++; $display("FAIL rstmid_distance: got %0d want 0", distance_cm); end
        @(negedge clk);
        rst_n = 1'b1;
        r0 = trig_rises;
        repeat (100) @(negedge clk);
        total++; if (trig_rises != r0) begin bad++; $display("FAIL rstmid_spurious_trig: rises=%0d want 0", trig_rises - r0); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_idle: busy=%b want 0", busy); end
    endtask

    initial begin
        test_reset();
        test_single_shot();
        test_no_echo();
        test_stuck_echo();
        test_continuous();
        test_abort();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
